// File: rtl/uart_mbox_pkg.sv
// Shared register map, STATUS/IRQ_EN bit positions and the STATUS word layout for uart_mbox.
package uart_mbox_pkg;

    localparam logic [3:0] REG_RX_PUSH = 4'h0;
    localparam logic [3:0] REG_RX_POP  = 4'h1;
    localparam logic [3:0] REG_TX_PUSH = 4'h2;
    localparam logic [3:0] REG_TX_POP  = 4'h3;
    localparam logic [3:0] REG_STATUS  = 4'h4;
    localparam logic [3:0] REG_IRQ_EN  = 4'h5;

    localparam int unsigned ST_RX_OVF     = 4;
    localparam int unsigned ST_TX_OVF     = 5;
    localparam int unsigned RX_COUNT_LSB  = 8;
    localparam int unsigned TX_COUNT_LSB  = 17;
    localparam int unsigned COUNT_FIELD_W = 9;

    localparam int unsigned IRQ_RX_NONEMPTY = 0;
    localparam int unsigned IRQ_TX_NOT_FULL = 1;
    localparam int unsigned IRQ_ANY_OVF     = 2;
    localparam int unsigned IRQ_EN_W        = 3;

    // Packed image of the STATUS register, MSB first.
    typedef struct packed {
        logic [5:0]               rsvd_hi;
        logic [COUNT_FIELD_W-1:0] tx_count;
        logic [COUNT_FIELD_W-1:0] rx_count;
        logic [1:0]               rsvd_lo;
        logic                     tx_ovf;
        logic                     rx_ovf;
        logic                     tx_full;
        logic                     tx_empty;
        logic                     rx_full;
        logic                     rx_empty;
    } status_t;

endpackage

// File: rtl/uart_mbox_fifo.sv
// Synchronous FIFO with first-word-fall-through head; pushes when full and pops when empty are ignored.
module uart_mbox_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_next;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_mbox.sv
// CSR mailbox with RX (host->CPU) and TX (CPU->host) FIFOs, sticky overflow flags and a level irq.
// Define UART_MBOX_IRQ_EN to build the IRQ_EN register and irq logic; otherwise irq stays 0.
module uart_mbox
    import uart_mbox_pkg::*;
#(
    parameter logic [3:0]  csr_addr = 4'h0,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic              bank_sel;
    logic              wr_sel;
    logic [3:0]        reg_sel;
    logic              rx_push, rx_pop, tx_push, tx_pop, st_wr;
    logic [DATA_W-1:0] rx_head, tx_head;
    logic [AW:0]       rx_count, tx_count;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic              rx_ovf, tx_ovf;
    logic [IRQ_EN_W-1:0] irq_en;
    logic [IRQ_EN_W-1:0] irq_src;
    logic              irq_next;
    status_t           status;
    logic [31:0]       rd_data;
    logic              unused_bits;

    assign unused_bits = ^{csr_a[9:4], csr_di};

    assign bank_sel = (csr_a[13:10] == csr_addr);
    assign wr_sel   = csr_we & bank_sel;
    assign reg_sel  = csr_a[3:0];
    assign rx_push  = wr_sel & (reg_sel == REG_RX_PUSH);
    assign rx_pop   = wr_sel & (reg_sel == REG_RX_POP);
    assign tx_push  = wr_sel & (reg_sel == REG_TX_PUSH);
    assign tx_pop   = wr_sel & (reg_sel == REG_TX_POP);
    assign st_wr    = wr_sel & (reg_sel == REG_STATUS);

    uart_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .push      (rx_push),
        .push_data (csr_di[DATA_W-1:0]),
        .pop       (rx_pop),
        .head_c    (rx_head),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    uart_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .push      (tx_push),
        .push_data (csr_di[DATA_W-1:0]),
        .pop       (tx_pop),
        .head_c    (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // Sticky overflow flags; a new overflow beats a same-cycle W1C.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            if (rx_push && rx_full)                rx_ovf <= 1'b1;
            else if (st_wr && csr_di[ST_RX_OVF])   rx_ovf <= 1'b0;
            if (tx_push && tx_full)                tx_ovf <= 1'b1;
            else if (st_wr && csr_di[ST_TX_OVF])   tx_ovf <= 1'b0;
        end
    end

`ifdef UART_MBOX_IRQ_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                                 irq_en <= '0;
        else if (wr_sel && reg_sel == REG_IRQ_EN)    irq_en <= csr_di[IRQ_EN_W-1:0];
    end
`else
    assign irq_en = '0;
`endif

    always_comb begin
        irq_src                  = '0;
        irq_src[IRQ_RX_NONEMPTY] = ~rx_empty;
        irq_src[IRQ_TX_NOT_FULL] = ~tx_full;
        irq_src[IRQ_ANY_OVF]     = rx_ovf | tx_ovf;
    end

    assign irq_next = |(irq_en & irq_src);

    always_comb begin
        status          = '0;
        status.tx_count = COUNT_FIELD_W'(tx_count);
        status.rx_count = COUNT_FIELD_W'(rx_count);
        status.tx_ovf   = tx_ovf;
        status.rx_ovf   = rx_ovf;
        status.tx_full  = tx_full;
        status.tx_empty = tx_empty;
        status.rx_full  = rx_full;
        status.rx_empty = rx_empty;
    end

    // Read mux sees pre-write state; head is masked to zero while its FIFO is empty.
    always_comb begin
        rd_data = '0;
        if (bank_sel) begin
            case (reg_sel)
                REG_RX_POP: begin
                    rd_data[DATA_W]     = ~rx_empty;
                    rd_data[DATA_W-1:0] = rx_empty ? '0 : rx_head;
                end
                REG_TX_POP: begin
                    rd_data[DATA_W]     = ~tx_empty;
                    rd_data[DATA_W-1:0] = tx_empty ? '0 : tx_head;
                end
                REG_STATUS: rd_data = status;
                REG_IRQ_EN: rd_data[IRQ_EN_W-1:0] = irq_en;
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            csr_do <= '0;
            irq    <= 1'b0;
        end else begin
            csr_do <= rd_data;
            irq    <= irq_next;
        end
    end

endmodule

// File: tb/tb_uart_mbox.sv
// Directed scoreboard bench for uart_mbox: stimulus queues expected csr_do/irq values, a monitor checks them.
module tb_uart_mbox;
    import uart_mbox_pkg::*;

    localparam logic [3:0] BANK     = 4'h0;
    localparam logic [3:0] BAD_BANK = 4'hA;
`ifdef UART_MBOX_IRQ_EN
    localparam logic       IRQ_ON   = 1'b1;
`else
    localparam logic       IRQ_ON   = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;

    typedef struct {
        bit          is_irq;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic        chk_issue;
    logic        chk_fire;
    logic        done;
    int          n_checks = 0;
    int          n_fails  = 0;
    exp_t        m_e;
    logic [31:0] m_act;

    uart_mbox #(.csr_addr(BANK), .DATA_W(8), .DEPTH(16)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_di  (csr_di),
        .csr_do  (csr_do),
        .irq     (irq)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) chk_fire <= chk_issue;

    // Monitor: compare the queued expectation once the registered output has updated.
    always @(negedge sys_clk) begin
        if (chk_fire === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fails++;
                $display("FAIL scoreboard_underflow: got no expectation, required one");
            end else begin
                m_e   = sb.pop_front();
                m_act = m_e.is_irq ? {31'b0, irq} : csr_do;
                if (m_act !== m_e.exp) begin
                    n_fails++;
                    $display("FAIL %s: got 0x%08h, required 0x%08h", m_e.name, m_act, m_e.exp);
                end
            end
        end
        if (done === 1'b1) begin
            n_checks++;
            if (sb.size() != 0) begin
                n_fails++;
                $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
            $finish;
        end
    end

    task automatic step(input logic [3:0] bank, input logic [3:0] r, input logic we,
                        input logic [31:0] di, input bit chk, input bit is_irq,
                        input logic [31:0] exp, input string nm);
        exp_t e;
        if (chk) begin
            e.is_irq = is_irq;
            e.exp    = exp;
            e.name   = nm;
            sb.push_back(e);
        end
        csr_a     = {bank, 6'b0, r};
        csr_we    = we;
        csr_di    = di;
        chk_issue = chk;
        @(posedge sys_clk);
        #1;
        csr_a     = '0;
        csr_we    = 1'b0;
        csr_di    = '0;
        chk_issue = 1'b0;
    endtask

    task automatic wr(input logic [3:0] r, input logic [31:0] di);
        step(BANK, r, 1'b1, di, 1'b0, 1'b0, 32'h0, "");
    endtask

    task automatic rd(input logic [3:0] r, input logic [31:0] exp, input string nm);
        step(BANK, r, 1'b0, 32'h0, 1'b1, 1'b0, exp, nm);
    endtask

    task automatic chk_irq(input logic exp, input string nm);
        step(BANK, 4'hF, 1'b0, 32'h0, 1'b1, 1'b1, {31'b0, exp}, nm);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL time_limit: got no end of test, required one");
        $fatal(1, "time limit reached");
    end

    initial begin
        logic [7:0] v;
        sys_rst   = 1'b1;
        csr_a     = '0;
        csr_we    = 1'b0;
        csr_di    = '0;
        chk_issue = 1'b0;
        done      = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // Reset state
        chk_irq(1'b0, "reset_irq");
        rd(REG_STATUS, 32'h0000_0005, "reset_status");
        rd(REG_RX_POP, 32'h0, "reset_rx_pop");
        rd(REG_TX_POP, 32'h0, "reset_tx_pop");

        // Basic RX push/pop
        wr(REG_RX_PUSH, 32'h41);
        wr(REG_RX_PUSH, 32'h42);
        rd(REG_STATUS, 32'h0000_0204, "rx_two_status");
        rd(REG_RX_POP, 32'h141, "rx_head_41");
        wr(REG_RX_POP, 32'h0);
        rd(REG_RX_POP, 32'h142, "rx_head_42");
        wr(REG_RX_POP, 32'h0);
        rd(REG_RX_POP, 32'h0, "rx_empty_read");
        rd(REG_STATUS, 32'h0000_0005, "rx_drained_status");
        wr(REG_RX_POP, 32'h0);
        rd(REG_STATUS, 32'h0000_0005, "pop_empty_no_flag");

        // TX fill to full plus one overflow
        for (int i = 0; i < 17; i++) wr(REG_TX_PUSH, 32'(i));
        rd(REG_STATUS, 32'h0020_0029, "tx_full_ovf_status");
        for (int i = 0; i < 16; i++) begin
            rd(REG_TX_POP, 32'h100 | 32'(i), $sformatf("tx_drain_%0d", i));
            wr(REG_TX_POP, 32'h0);
        end
        rd(REG_STATUS, 32'h0000_0025, "tx_drained_ovf_sticky");
        wr(REG_STATUS, 32'h20);
        rd(REG_STATUS, 32'h0000_0005, "tx_ovf_w1c");

        // Pointer wrap on RX
        for (int i = 0; i < 40; i++) begin
            v = 8'((i * 7 + 3) & 8'hFF);
            wr(REG_RX_PUSH, {24'h0, v});
            rd(REG_STATUS, 32'h0000_0104, $sformatf("wrap_status_%0d", i));
            rd(REG_RX_POP, {23'h0, 1'b1, v}, $sformatf("wrap_data_%0d", i));
            wr(REG_RX_POP, 32'h0);
        end
        rd(REG_STATUS, 32'h0000_0005, "wrap_end_status");

        // Interrupt enable and level behaviour
        wr(REG_IRQ_EN, 32'h1);
        rd(REG_IRQ_EN, {31'h0, IRQ_ON}, "irq_en_readback");
        chk_irq(1'b0, "irq_rx_empty");
        wr(REG_RX_PUSH, 32'h55);
        chk_irq(IRQ_ON, "irq_after_push");
        wr(REG_RX_POP, 32'h0);
        chk_irq(1'b0, "irq_after_pop");
        wr(REG_RX_PUSH, 32'h66);
        chk_irq(IRQ_ON, "irq_after_push2");
        wr(REG_IRQ_EN, 32'h0);
        chk_irq(1'b0, "irq_disabled");
        wr(REG_RX_POP, 32'h0);
        wr(REG_IRQ_EN, 32'h2);
        chk_irq(IRQ_ON, "irq_tx_not_full");
        wr(REG_IRQ_EN, 32'h0);
        chk_irq(1'b0, "irq_tx_not_full_off");

        // Bank mismatch is invisible
        step(BAD_BANK, REG_RX_PUSH, 1'b1, 32'h77, 1'b0, 1'b0, 32'h0, "");
        step(BAD_BANK, REG_TX_PUSH, 1'b1, 32'h78, 1'b0, 1'b0, 32'h0, "");
        step(BAD_BANK, REG_IRQ_EN, 1'b1, 32'h7, 1'b0, 1'b0, 32'h0, "");
        step(BAD_BANK, REG_STATUS, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "bank_miss_read");
        rd(REG_STATUS, 32'h0000_0005, "bank_miss_status");
        rd(REG_IRQ_EN, 32'h0, "bank_miss_irq_en");

        // RX overflow, W1C and partial drain
        for (int i = 0; i < 17; i++) wr(REG_RX_PUSH, 32'(8'hA0 + i));
        rd(REG_STATUS, 32'h0000_1016, "rx_full_ovf_status");
        wr(REG_STATUS, 32'h10);
        rd(REG_STATUS, 32'h0000_1006, "rx_ovf_w1c");
        rd(REG_RX_POP, 32'h1A0, "rx_full_head");
        wr(REG_RX_POP, 32'h0);
        rd(REG_STATUS, 32'h0000_0F04, "rx_one_popped");

        // Reset mid-traffic with queued entries
        do_reset();
        rd(REG_STATUS, 32'h0000_0005, "reset_after_full");
        for (int i = 0; i < 5; i++) wr(REG_RX_PUSH, 32'(8'h30 + i));
        rd(REG_STATUS, 32'h0000_0504, "five_queued");
        do_reset();
        rd(REG_STATUS, 32'h0000_0005, "reset_five_status");
        rd(REG_RX_POP, 32'h0, "reset_five_rx_pop");
        chk_irq(1'b0, "reset_five_irq");

        repeat (2) @(posedge sys_clk);
        #1;
        done = 1'b1;
    end

endmodule
